// File: rtl/lib_arbiter_pkg.sv
// Shared types for the group readout scheduler: FSM states and the tagged pixel event.
package lib_arbiter_pkg;

  localparam int SCHED_GRP_ADD = 2;
  localparam int SCHED_ROW_ADD = 2;
  localparam int SCHED_COL_ADD = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_GRP_ADD-1:0] grp;
    logic [SCHED_ROW_ADD-1:0] x;
    logic [SCHED_COL_ADD-1:0] y;
  } sched_evt_t;

endpackage

// File: rtl/sched_event_fifo.sv
// First-word-fall-through event FIFO; head valid the cycle after the first push.
// A push while full is rejected even if a pop happens in the same cycle.
module sched_event_fifo
  import lib_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       grp_release_clk,
  input  logic                       reset_i,
  input  logic                       push,
  input  sched_evt_t                 push_evt,
  input  logic                       pop,
  output sched_evt_t                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sched_evt_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;
  logic [CW-1:0]  count_nxt;

  assign full        = (count == CW'(DEPTH));
  assign push_ok     = push && !full;
  assign pop_ok      = pop && (count != '0);
  assign count_nxt   = count + CW'(push_ok) - CW'(pop_ok);
  // Looks at the post-update level so the scheduler can pause one cycle early.
  assign almost_full = (count_nxt >= CW'(DEPTH - 1));
  assign head        = mem[rd_ptr];

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge grp_release_clk) begin
    if (push_ok) mem[wr_ptr] <= push_evt;
  end

endmodule

// File: rtl/grp_readout_scheduler.sv
// Round-robin scheduler sharing one event readout path among NUM_GRPS pixel groups.
// Define SCHED_BURST_LIMIT_EN to force rotation after MAX_BURST events per tenure.
module grp_readout_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int NUM_GRPS   = 4,
  parameter int GRP_ADD    = 2,
  parameter int ROW_ADD    = 2,
  parameter int COL_ADD    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                        grp_release_clk,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [NUM_GRPS-1:0]         grp_req_i,
  input  logic [NUM_GRPS-1:0]         grp_active_i,
  input  logic [NUM_GRPS*ROW_ADD-1:0] grp_x_add_i,
  input  logic [NUM_GRPS*COL_ADD-1:0] grp_y_add_i,
  input  logic [NUM_GRPS-1:0]         grp_release_i,
  output logic [NUM_GRPS-1:0]         grp_enable_o,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [GRP_ADD-1:0]          evt_grp_o,
  output logic [ROW_ADD-1:0]          evt_x_o,
  output logic [COL_ADD-1:0]          evt_y_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic                        grp_release_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_BURST < 1 ||
      (1 << GRP_ADD) < NUM_GRPS || GRP_ADD != SCHED_GRP_ADD ||
      ROW_ADD != SCHED_ROW_ADD || COL_ADD != SCHED_COL_ADD) begin : g_cfg_check
    $error("grp_readout_scheduler: unsupported parameter combination");
  end

  sched_state_t       state;
  logic [GRP_ADD-1:0] cur;
  logic [GRP_ADD-1:0] last;
  logic [GRP_ADD-1:0] win;
  logic [ROW_ADD-1:0] cur_x;
  logic [COL_ADD-1:0] cur_y;
  logic               observe;
  logic               push;
  logic               drop;
  logic               pop;
  logic               full;
  logic               almost_full;
  logic [CW-1:0]      count;
  logic               burst_hit;
  sched_evt_t         push_evt;
  sched_evt_t         head;

  function automatic logic [GRP_ADD-1:0] rr_winner(input logic [NUM_GRPS-1:0] req,
                                                    input logic [GRP_ADD-1:0]  from);
    logic [GRP_ADD-1:0] pick;
    logic [GRP_ADD-1:0] idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_GRPS; k++) begin
      idx = GRP_ADD'((int'(from) + k) % NUM_GRPS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_GRPS-1:0] grp_onehot(input logic [GRP_ADD-1:0] g);
    logic [NUM_GRPS-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  assign win = rr_winner(grp_req_i, last);

  always_comb begin
    cur_x = '0;
    cur_y = '0;
    for (int g = 0; g < NUM_GRPS; g++) begin
      if (GRP_ADD'(g) == cur) begin
        cur_x = grp_x_add_i[g*ROW_ADD +: ROW_ADD];
        cur_y = grp_y_add_i[g*COL_ADD +: COL_ADD];
      end
    end
  end

  // HOLD still accepts the one event already in flight when the enable dropped.
  assign observe  = ((state == SERVE) || (state == HOLD)) && grp_active_i[cur];
  assign push     = observe && !full;
  assign drop     = observe && full;
  assign pop      = evt_valid_o && evt_ready_i;
  assign push_evt = '{grp: cur, x: cur_x, y: cur_y};

  sched_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .grp_release_clk (grp_release_clk),
    .reset_i         (reset_i),
    .push            (push),
    .push_evt        (push_evt),
    .pop             (pop),
    .head            (head),
    .count           (count),
    .full            (full),
    .almost_full     (almost_full)
  );

  assign evt_valid_o = (count != '0);
  assign evt_grp_o   = evt_valid_o ? head.grp : '0;
  assign evt_x_o     = evt_valid_o ? head.x   : '0;
  assign evt_y_o     = evt_valid_o ? head.y   : '0;

`ifdef SCHED_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_nxt;

  assign burst_nxt = burst_cnt + BW'(push);
  assign burst_hit = (burst_nxt >= BW'(MAX_BURST));

  // Only SERVE pushes count toward the tenure; HOLD keeps the running total.
  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
    end else if (state == SERVE) begin
      burst_cnt <= burst_nxt;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      cur           <= '0;
      last          <= GRP_ADD'(NUM_GRPS - 1);
      grp_enable_o  <= '0;
      busy_o        <= 1'b0;
      overflow_o    <= 1'b0;
      grp_release_o <= 1'b0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      grp_release_o <= 1'b0;
      case (state)
        IDLE: begin
          grp_release_o <= enable_i && (grp_req_i == '0);
          if (enable_i && (grp_req_i != '0)) begin
            cur          <= win;
            grp_enable_o <= grp_onehot(win);
            busy_o       <= 1'b1;
            state        <= SERVE;
          end
        end
        SERVE: begin
          if (!enable_i) begin
            grp_enable_o <= '0;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end else if (grp_release_i[cur] || !grp_req_i[cur] || burst_hit) begin
            grp_enable_o <= '0;
            state        <= RELEASE;
          end else if (almost_full) begin
            grp_enable_o <= '0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (!enable_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (count <= CW'(FIFO_DEPTH / 2)) begin
            grp_enable_o <= grp_onehot(cur);
            state        <= SERVE;
          end
        end
        RELEASE: begin
          last   <= cur;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          grp_enable_o <= '0;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grp_readout_scheduler.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_grp_readout_scheduler;

  localparam int NG    = 4;
  localparam int RA    = 2;
  localparam int CA    = 2;
  localparam int DEPTH = 4;
  localparam int MAXB  = 8;
`ifdef SCHED_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en  = 1'b0;
  logic            rdy = 1'b0;
  logic [NG-1:0]   req = '0;
  logic [NG-1:0]   act = '0;
  logic [NG-1:0]   rel_i = '0;
  logic [NG*RA-1:0] xa = '0;
  logic [NG*CA-1:0] ya = '0;

  logic [NG-1:0] en_o;
  logic          vld;
  logic [1:0]    grp_o;
  logic [1:0]    x_o;
  logic [1:0]    y_o;
  logic          busy;
  logic          ovf;
  logic          rel_o;

  always #5 clk = ~clk;

  grp_readout_scheduler #(
    .NUM_GRPS (NG), .GRP_ADD (2), .ROW_ADD (RA), .COL_ADD (CA),
    .FIFO_DEPTH (DEPTH), .MAX_BURST (MAXB)
  ) dut (
    .grp_release_clk (clk),
    .reset_i         (rst),
    .enable_i        (en),
    .grp_req_i       (req),
    .grp_active_i    (act),
    .grp_x_add_i     (xa),
    .grp_y_add_i     (ya),
    .grp_release_i   (rel_i),
    .grp_enable_o    (en_o),
    .evt_valid_o     (vld),
    .evt_ready_i     (rdy),
    .evt_grp_o       (grp_o),
    .evt_x_o         (x_o),
    .evt_y_o         (y_o),
    .busy_o          (busy),
    .overflow_o      (ovf),
    .grp_release_o   (rel_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the path, whether it is paused or closing, and the event queue.
  bit            has_owner;
  logic [1:0]    o;
  bit            paused;
  bit            closing;
  logic [1:0]    m_last;
  logic [NG-1:0] m_en;
  bit            m_rel;
  bit            m_ovf;
  int            m_burst;
  logic [5:0]    m_q[$];

  task automatic model_reset();
    has_owner = 1'b0; o = 2'd0; paused = 1'b0; closing = 1'b0;
    m_last = 2'(NG - 1); m_en = '0; m_rel = 1'b0; m_ovf = 1'b0; m_burst = 0;
    m_q.delete();
  endtask

  function automatic logic [1:0] pick_next(input logic [NG-1:0] r, input logic [1:0] after);
    for (int k = 1; k <= NG; k++) begin
      logic [1:0] g;
      g = 2'((int'(after) + k) % NG);
      if (r[g]) return g;
    end
    return 2'd0;
  endfunction

  task automatic model_step();
    int cnt0;
    bit did_pop, obs, was_full, pushed;
    logic [1:0] ex, ey;
    cnt0     = m_q.size();
    did_pop  = (cnt0 != 0) && rdy;
    obs      = has_owner && !closing && act[o];
    was_full = (cnt0 == DEPTH);
    pushed   = obs && !was_full;
    ex       = 2'(xa >> (int'(o) * RA));
    ey       = 2'(ya >> (int'(o) * CA));
    if (obs && was_full) m_ovf = 1'b1;
    if (did_pop) void'(m_q.pop_front());
    if (pushed) m_q.push_back({o, ex, ey});
    m_rel = 1'b0;
    if (!has_owner) begin
      m_rel = en && (req == '0);
      if (en && (req != '0)) begin
        o = pick_next(req, m_last);
        has_owner = 1'b1;
        m_en = NG'(1) << o;
        m_burst = 0;
      end
    end else if (closing) begin
      m_last = o; has_owner = 1'b0; closing = 1'b0;
    end else if (!paused) begin
      if (pushed) m_burst++;
      if (!en) begin
        has_owner = 1'b0; m_en = '0;
      end else if (rel_i[o] || !req[o] || (BURST_ON && m_burst >= MAXB)) begin
        closing = 1'b1; m_en = '0;
      end else if (m_q.size() >= DEPTH - 1) begin
        paused = 1'b1; m_en = '0;
      end
    end else begin
      if (!en) begin
        has_owner = 1'b0; paused = 1'b0; m_en = '0;
      end else if (cnt0 <= DEPTH / 2) begin
        paused = 1'b0; m_en = NG'(1) << o;
      end
    end
  endtask

  task automatic compare_all();
    logic [5:0] hd;
    hd = (m_q.size() != 0) ? m_q[0] : 6'd0;
    chk("grp_enable",  32'(en_o),  32'(m_en));
    chk("busy",        32'(busy),  32'(has_owner));
    chk("overflow",    32'(ovf),   32'(m_ovf));
    chk("grp_release", 32'(rel_o), 32'(m_rel));
    chk("evt_valid",   32'(vld),   32'(m_q.size() != 0));
    chk("evt_grp",     32'(grp_o), 32'(hd[5:4]));
    chk("evt_x",       32'(x_o),   32'(hd[3:2]));
    chk("evt_y",       32'(y_o),   32'(hd[1:0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_enable"},  32'(en_o),  32'd0);
    chk({tag, "_valid"},   32'(vld),   32'd0);
    chk({tag, "_evt"},     32'({grp_o, x_o, y_o}), 32'd0);
    chk({tag, "_busy"},    32'(busy),  32'd0);
    chk({tag, "_ovf"},     32'(ovf),   32'd0);
    chk({tag, "_release"}, 32'(rel_o), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int  n0;
  bit  did_mid_rst;

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Round-robin start at group 0, release gap, then group 2.
    en = 1'b1; rdy = 1'b1; req = 4'b0101;
    cycle(); chk("first_grant", 32'(en_o), 32'h1);
    cycle();
    rel_i = 4'b0001;
    cycle(); chk("release_gap", 32'(en_o), 32'h0); chk("release_busy", 32'(busy), 32'h1);
    rel_i = '0; req = 4'b0100;
    cycle(); cycle(); chk("second_grant", 32'(en_o), 32'h4);

    // Hand over to group 1 and read one tagged event.
    req = 4'b0010;
    for (int i = 0; i < 8 && m_en != 4'b0010; i++) cycle();
    chk("grp1_grant", 32'(en_o), 32'h2);
    act = 4'b0010; xa = 8'b0000_1000; ya = 8'b0000_1100;
    cycle();
    act = '0;
    chk("evt1_valid", 32'(vld), 32'h1);
    chk("evt1_grp", 32'(grp_o), 32'h1);
    chk("evt1_x", 32'(x_o), 32'h2);
    chk("evt1_y", 32'(y_o), 32'h3);
    cycle();

    // Stall the consumer: pause, in-flight event, then an overflowing one.
    rdy = 1'b0; act = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      xa = 8'($urandom); ya = 8'($urandom);
      cycle();
      if (i == 2) begin
        chk("hold_enable", 32'(en_o), 32'h0);
        chk("hold_busy", 32'(busy), 32'h1);
      end
    end
    chk("overflow_set", 32'(ovf), 32'h1);
    act = '0; rdy = 1'b1;
    for (int i = 0; i < 10 && m_en != 4'b0010; i++) cycle();
    chk("resume_serve", 32'(en_o), 32'h2);

    // Drop enable mid-tenure; the FIFO keeps draining.
    rdy = 1'b0; en = 1'b0; act = 4'b0010;
    cycle();
    act = '0;
    chk("disable_enable", 32'(en_o), 32'h0);
    chk("disable_busy", 32'(busy), 32'h0);
    chk("drain_after_disable", 32'(vld), 32'h1);
    rdy = 1'b1;
    repeat (4) cycle();
    chk("drained", 32'(vld), 32'h0);

    en = 1'b1; req = '0;
    cycle(); cycle();
    chk("all_released", 32'(rel_o), 32'h1);

`ifdef SCHED_BURST_LIMIT_EN
    req = 4'b0011; act = 4'b0001; rdy = 1'b1; n0 = 0;
    for (int i = 0; i < 40 && en_o != 4'b0010; i++) begin
      xa = 8'($urandom); ya = 8'($urandom);
      cycle();
      if (vld && grp_o == 2'd0) n0++;
    end
    chk("burst_rotation", 32'(n0), 32'd8);
    act = '0; req = '0;
    repeat (4) cycle();
`endif

    // Random traffic, with one asynchronous reset while a tenure is in progress.
    did_mid_rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 99) < 97);
      rdy = ($urandom_range(0, 99) < 55);
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(0, 99) < 8) req[g] = ~req[g];
        act[g]   = ($urandom_range(0, 99) < 70);
        rel_i[g] = ($urandom_range(0, 99) < 4);
      end
      xa = 8'($urandom); ya = 8'($urandom);
      cycle();
      if (!did_mid_rst && i > 1500 && has_owner && m_q.size() != 0) begin
        do_reset("mid_reset");
        did_mid_rst = 1'b1;
      end
    end
    chk("mid_reset_reached", 32'(did_mid_rst), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
